// File: rtl/rect_pkg.sv
// Shared definitions for the rect_renderer chain: field widths, register IDs
// and the programmer's sequencing states.
package rect_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 12;
  localparam int D_W = 12;

  localparam logic [Y_W-1:0] REG_X     = Y_W'(0);
  localparam logic [Y_W-1:0] REG_Y     = Y_W'(1);
  localparam logic [Y_W-1:0] REG_W     = Y_W'(2);
  localparam logic [Y_W-1:0] REG_H     = Y_W'(3);
  localparam logic [Y_W-1:0] REG_COLOR = Y_W'(4);

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic [D_W-1:0] color;
  } shape_t;

  function automatic logic [D_W-1:0] zext_x(input logic [X_W-1:0] v);
    return {{(D_W-X_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/chain_word_mux.sv
// Registered output stage of the programmer: drives either a program word or
// the scan coordinates with the background colour onto the chain bus.
module chain_word_mux
  import rect_pkg::*;
#(
  parameter logic [D_W-1:0] BG_COLOR = 12'h000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           prog_valid,
  input  logic [X_W-1:0] prog_x,
  input  logic [Y_W-1:0] prog_y,
  input  logic [D_W-1:0] prog_data,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output logic           program_out,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [D_W-1:0] data_out
);

  logic           program_d, program_q;
  logic [X_W-1:0] x_d, x_q;
  logic [Y_W-1:0] y_d, y_q;
  logic [D_W-1:0] data_d, data_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    program_d = 1'b0;
    x_d       = pix_x;
    y_d       = pix_y;
    data_d    = BG_COLOR;
    if (prog_valid) begin
      program_d = 1'b1;
      x_d       = prog_x;
      y_d       = prog_y;
      data_d    = prog_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      program_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      data_q    <= '0;
    end else begin
      program_q <= program_d;
      x_q       <= x_d;
      y_q       <= y_d;
      data_q    <= data_d;
    end
  end

  assign program_out = program_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign data_out    = data_q;

endmodule

// File: rtl/shape_chain_programmer.sv
// Head of the rect_renderer chain: serialises shape-write and clear-all commands
// into program words during blanking, otherwise forwards scan coordinates.
module shape_chain_programmer
  import rect_pkg::*;
#(
  parameter int             NUM_SHAPES = 8,
  parameter logic [D_W-1:0] BG_COLOR   = 12'h000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_clear,
  input  logic [X_W-1:0] cmd_index,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] cmd_w,
  input  logic [Y_W-1:0] cmd_h,
  input  logic [D_W-1:0] cmd_color,
  output logic           cmd_error,
  input  logic           blank,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  output logic           busy,
  output logic           program_out,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [D_W-1:0] data_out
);

  localparam logic [X_W-1:0] NUM_SHAPES_X = X_W'(NUM_SHAPES);
  localparam logic [X_W-1:0] LAST_SHAPE   = X_W'(NUM_SHAPES - 1);
  localparam logic [2:0]     LAST_WORD    = 3'd4;

  state_e         state_d, state_q;
  logic [2:0]     wc_d, wc_q;
  logic [X_W-1:0] sc_d, sc_q;
  logic [X_W-1:0] idx_d, idx_q;
  shape_t         shape_d, shape_q;
  logic           err_d, err_q;

  logic           word_valid;
  logic [X_W-1:0] word_x;
  logic [Y_W-1:0] word_y;
  logic [D_W-1:0] word_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wc_q    <= '0;
      sc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      sc_q    <= sc_d;
      err_q   <= err_d;
    end
  end

  // NOTE: latched command fields carry no reset; they are only read after a load.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    shape_q <= shape_d;
  end

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    shape_d = shape_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_clear) begin
            state_d = CLEAR;
            sc_d    = '0;
          end else if (cmd_index < NUM_SHAPES_X) begin
            state_d = SEND;
            wc_d    = '0;
            idx_d   = cmd_index;
            shape_d = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (blank) begin
          wc_d = wc_q + 3'd1;
          if (wc_q == LAST_WORD) state_d = IDLE;
        end
      end
      CLEAR: begin
        if (blank) begin
          sc_d = sc_q + X_W'(1);
          if (sc_q == LAST_SHAPE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters only advance on blank cycles, so a paused sequence resumes at the same word.
  always_comb begin
    cmd_ready  = (state_q == IDLE) && !rst;
    busy       = (state_q != IDLE);
    word_valid = 1'b0;
    word_x     = idx_q;
    word_y     = '0;
    word_d     = '0;
    unique case (state_q)
      SEND: begin
        word_valid = blank;
        word_y     = Y_W'(wc_q);
        case (wc_q)
          3'd0:    word_d = zext_x(shape_q.x);
          3'd1:    word_d = shape_q.y;
          3'd2:    word_d = zext_x(shape_q.w);
          3'd3:    word_d = shape_q.h;
          default: word_d = shape_q.color;
        endcase
      end
      CLEAR: begin
        word_valid = blank;
        word_x     = sc_q;
        word_y     = REG_W;
      end
      default: ;
    endcase
  end

  assign cmd_error = err_q;

  chain_word_mux #(.BG_COLOR(BG_COLOR)) u_word_mux (
    .clk        (clk),
    .rst        (rst),
    .prog_valid (word_valid),
    .prog_x     (word_x),
    .prog_y     (word_y),
    .prog_data  (word_d),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .program_out(program_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .data_out   (data_out)
  );

endmodule

// File: tb/tb_shape_chain_programmer.sv
// Self-checking bench: a queue-of-words reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_shape_chain_programmer;

  localparam int          NUM_SHAPES = 8;
  localparam logic [11:0] BG         = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_clear, cmd_error;
  logic [10:0] cmd_index, cmd_x, cmd_w;
  logic [11:0] cmd_y, cmd_h, cmd_color;
  logic        blank, busy, program_out;
  logic [10:0] pix_x, x_out;
  logic [11:0] pix_y, y_out, data_out;

  shape_chain_programmer #(.NUM_SHAPES(NUM_SHAPES), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_index(cmd_index), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color), .cmd_error(cmd_error),
    .blank(blank), .pix_x(pix_x), .pix_y(pix_y), .busy(busy),
    .program_out(program_out), .x_out(x_out), .y_out(y_out), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] x;
    logic [11:0] y;
    logic [11:0] d;
  } word_t;

  word_t       pending[$];
  logic        model_valid = 1'b0;
  logic        m_prog, m_err, m_acc;
  logic [10:0] m_x;
  logic [11:0] m_y, m_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a command becomes a list of words; one leaves per blanking cycle.
  task automatic model_step();
    word_t w;
    logic  popped;
    m_acc = 1'b0;
    if (rst) begin
      pending.delete();
      model_valid = 1'b1;
      {m_prog, m_err} = 2'b00;
      m_x = '0; m_y = '0; m_d = '0;
    end else begin
      m_err  = 1'b0;
      m_acc  = cmd_valid && (pending.size() == 0);
      popped = blank && (pending.size() != 0);
      if (popped) w = pending.pop_front();
      m_prog = popped;
      m_x    = popped ? w.x : pix_x;
      m_y    = popped ? w.y : pix_y;
      m_d    = popped ? w.d : BG;
      if (m_acc) begin
        if (cmd_clear) begin
          for (int s = 0; s < NUM_SHAPES; s++) pending.push_back('{11'(s), 12'd2, 12'd0});
        end else if (int'(cmd_index) < NUM_SHAPES) begin
          pending.push_back('{cmd_index, 12'd0, {1'b0, cmd_x}});
          pending.push_back('{cmd_index, 12'd1, cmd_y});
          pending.push_back('{cmd_index, 12'd2, {1'b0, cmd_w}});
          pending.push_back('{cmd_index, 12'd3, cmd_h});
          pending.push_back('{cmd_index, 12'd4, cmd_color});
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    if (model_valid) begin
      check("program_out", 32'(program_out), 32'(m_prog));
      check("x_out", 32'(x_out), 32'(m_x));
      check("y_out", 32'(y_out), 32'(m_y));
      check("data_out", 32'(data_out), 32'(m_d));
      check("cmd_error", 32'(cmd_error), 32'(m_err));
      check("busy", 32'(busy), 32'(pending.size() != 0));
      check("cmd_ready", 32'(cmd_ready), 32'((pending.size() == 0) && !rst));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_write(input logic [10:0] idx, input logic [10:0] x, input logic [11:0] y,
                           input logic [10:0] w, input logic [11:0] h, input logic [11:0] c);
    cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_index = idx;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
  endtask

  logic [11:0] lit_data[5] = '{12'd10, 12'd20, 12'd30, 12'd40, 12'hF00};
  logic        pat[8]      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int          word_seq[8] = '{0, 1, -1, -1, -1, 2, 3, 4};

  initial begin
    int waited;
    rst = 1'b1; cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_index = '0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    blank = 1'b0; pix_x = 11'd7; pix_y = 12'd9;
    cycle(); cycle();
    check("reset program_out", 32'(program_out), 32'd0);
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    cycle();
    check("idle cmd_ready", 32'(cmd_ready), 32'd1);

    // Shape write with continuous blanking.
    blank = 1'b1;
    set_write(11'd2, 11'd10, 12'd20, 11'd30, 12'd40, 12'hF00);
    cycle();
    cmd_valid = 1'b0;
    check("busy after accept", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("write prog", 32'(program_out), 32'd1);
      check("write x", 32'(x_out), 32'd2);
      check("write y", 32'(y_out), 32'(i));
      check("write data", 32'(data_out), 32'(lit_data[i]));
    end
    cycle();
    check("after write prog", 32'(program_out), 32'd0);
    check("after write busy", 32'(busy), 32'd0);
    check("after write ready", 32'(cmd_ready), 32'd1);

    // Same write with blanking dropping mid-sequence.
    set_write(11'd2, 11'd10, 12'd20, 11'd30, 12'd40, 12'hF00);
    cycle();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      blank = pat[k];
      pix_x = 11'(100 + k);
      pix_y = 12'(200 + k);
      cycle();
      check("pause prog", 32'(program_out), 32'(pat[k]));
      if (word_seq[k] >= 0) begin
        check("pause word", 32'(y_out), 32'(word_seq[k]));
      end else begin
        check("pause pix_x", 32'(x_out), 32'(100 + k));
        check("pause bg", 32'(data_out), 32'(BG));
        check("pause busy", 32'(busy), 32'd1);
      end
    end

    // Out-of-range index.
    blank = 1'b1;
    set_write(11'd8, 11'd1, 12'd1, 11'd1, 12'd1, 12'h111);
    cycle();
    cmd_valid = 1'b0;
    check("bad idx error", 32'(cmd_error), 32'd1);
    check("bad idx busy", 32'(busy), 32'd0);
    cycle();
    check("bad idx pulse", 32'(cmd_error), 32'd0);
    check("bad idx prog", 32'(program_out), 32'd0);

    // Clear-all with a write held waiting behind it.
    cmd_valid = 1'b1; cmd_clear = 1'b1;
    cycle();
    set_write(11'd3, 11'd50, 12'd60, 11'd70, 12'd80, 12'h0AB);
    for (int i = 0; i < NUM_SHAPES; i++) begin
      cycle();
      check("clear prog", 32'(program_out), 32'd1);
      check("clear x", 32'(x_out), 32'(i));
      check("clear y", 32'(y_out), 32'd2);
      check("clear data", 32'(data_out), 32'd0);
    end
    check("held ready after clear", 32'(cmd_ready), 32'd1);
    cycle();
    cmd_valid = 1'b0;
    check("held accepted", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    check("held last word", 32'(data_out), 32'h0AB);

    // Reset in the middle of a write.
    set_write(11'd1, 11'd5, 12'd0, 11'd2, 12'd1, 12'h0F0);
    cycle();
    cmd_valid = 1'b0;
    cycle(); cycle(); cycle();
    check("word2 before reset", 32'(y_out), 32'd2);
    rst = 1'b1;
    cycle();
    check("mid reset prog", 32'(program_out), 32'd0);
    check("mid reset x", 32'(x_out), 32'd0);
    check("mid reset y", 32'(y_out), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("post reset prog", 32'(program_out), 32'd0);
    end

    // A held request must eventually be taken.
    waited = 0;
    set_write(11'd0, 11'd1, 12'd2, 11'd3, 12'd4, 12'h005);
    blank = 1'b0;
    cycle();
    while (!m_acc && waited < 40) begin
      cycle();
      waited++;
    end
    if (waited >= 40) check("accept timeout", 32'd1, 32'd0);
    cmd_valid = 1'b0;
    blank = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      blank     = ($urandom_range(0, 9) < 7);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_clear = ($urandom_range(0, 5) == 0);
      cmd_index = 11'($urandom_range(0, 10));
      cmd_x     = 11'($urandom);
      cmd_y     = 12'($urandom);
      cmd_w     = 11'($urandom);
      cmd_h     = 12'($urandom);
      cmd_color = 12'($urandom);
      pix_x     = 11'($urandom);
      pix_y     = 12'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
